// File: rtl/wb_rr_arbiter_if.sv
// Wishbone bus bundle for one master/slave link of the round-robin arbiter.
// Latency: none (wires only).
// Backpressure: the slave throttles with ack/err; the master holds stb until one of them arrives.
//   master modport: drives adr/sel/we/dat_w/cyc/stb, receives dat_r/ack/err
//   slave  modport: the opposite direction of every signal
interface wb_rr_arbiter_if #(
   parameter int AW = 32,
   parameter int DW = 128
);
   localparam int SW = DW / 8;

   logic [AW-1:0] adr;
   logic [SW-1:0] sel;
   logic          we;
   logic [DW-1:0] dat_w;
   logic          cyc;
   logic          stb;
   logic [DW-1:0] dat_r;
   logic          ack;
   logic          err;

   modport master (output adr, sel, we, dat_w, cyc, stb,
                   input  dat_r, ack, err);

   modport slave  (input  adr, sel, we, dat_w, cyc, stb,
                   output dat_r, ack, err);
endinterface

// File: rtl/wb_rr_arbiter.sv
// Two-master/one-slave Wishbone round-robin arbiter; a grant lasts for a whole CYC.
// Latency: grant registered one edge after a request is seen in IDLE; data/ack/err combinational.
// Backpressure: the slave's ack/err gate the owner only; the other master waits with no response.
//   i_clk, i_rst : clock and synchronous active-high reset
//   m0, m1       : master-facing links (m0 = core, m1 = backdoor loader)
//   s            : slave-facing link
//   o_gnt        : one-hot current owner, 2'b00 when idle
module wb_rr_arbiter #(
   parameter int TIMEOUT = 255   // 0 disables the synthetic ERR; max 65535
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   wb_rr_arbiter_if.slave       m0,
   wb_rr_arbiter_if.slave       m1,
   wb_rr_arbiter_if.master      s,
   output logic [1:0]           o_gnt
);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] GNT0 = 2'd1;
   localparam logic [1:0] GNT1 = 2'd2;

   localparam logic        TMO_EN  = (TIMEOUT != 0);
   localparam logic [15:0] TMO_LIM = 16'(TIMEOUT);

   logic [1:0]  state;
   logic        last_gnt;   // 1: m1 owned the bus last, so m0 wins the next tie
   logic [15:0] tmo_cnt;

   logic own_cyc;
   logic own_stb;
   logic tmo;
   logic ack_fwd;
   logic err_fwd;

   // Owner's request lines; zero when idle so nothing leaks to the slave.
   always_comb begin
      own_cyc = 1'b0;
      own_stb = 1'b0;
      case (state)
         GNT0: begin
            own_cyc = m0.cyc;
            own_stb = m0.stb;
         end
         GNT1: begin
            own_cyc = m1.cyc;
            own_stb = m1.stb;
         end
         default: ;
      endcase
   end

   // A slave response in the same cycle as the timeout wins: ACK goes through, no synthetic ERR.
   assign tmo     = TMO_EN && own_stb && !s.ack && !s.err && (tmo_cnt == TMO_LIM);
   assign ack_fwd = s.ack & own_stb;
   assign err_fwd = (s.err | tmo) & own_stb;

   always_comb begin
      s.adr   = '0;
      s.sel   = '0;
      s.we    = 1'b0;
      s.dat_w = '0;
      s.cyc   = 1'b0;
      s.stb   = 1'b0;
      m0.dat_r = '0;
      m0.ack   = 1'b0;
      m0.err   = 1'b0;
      m1.dat_r = '0;
      m1.ack   = 1'b0;
      m1.err   = 1'b0;
      case (state)
         GNT0: begin
            s.adr    = m0.adr;
            s.sel    = m0.sel;
            s.we     = m0.we;
            s.dat_w  = m0.dat_w;
            s.cyc    = m0.cyc;
            s.stb    = m0.stb;
            m0.dat_r = s.dat_r;
            m0.ack   = ack_fwd;
            m0.err   = err_fwd;
         end
         GNT1: begin
            s.adr    = m1.adr;
            s.sel    = m1.sel;
            s.we     = m1.we;
            s.dat_w  = m1.dat_w;
            s.cyc    = m1.cyc;
            s.stb    = m1.stb;
            m1.dat_r = s.dat_r;
            m1.ack   = ack_fwd;
            m1.err   = err_fwd;
         end
         default: ;
      endcase
   end

   assign o_gnt = {state == GNT1, state == GNT0};

   // Grant FSM: a CYC is never preempted, and releasing always passes through IDLE once.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state    <= IDLE;
         last_gnt <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (m0.cyc && m1.cyc)
                  state <= last_gnt ? GNT0 : GNT1;
               else if (m0.cyc)
                  state <= GNT0;
               else if (m1.cyc)
                  state <= GNT1;
            end
            GNT0: begin
               if (!m0.cyc) begin
                  state    <= IDLE;
                  last_gnt <= 1'b0;
               end
            end
            GNT1: begin
               if (!m1.cyc) begin
                  state    <= IDLE;
                  last_gnt <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Counts strobe cycles still waiting for a response; saturates so it can never wrap into a
   // false match.
   always_ff @(posedge i_clk) begin
      if (i_rst || !own_cyc || !own_stb || s.ack || s.err || tmo)
         tmo_cnt <= '0;
      else if (tmo_cnt != 16'hFFFF)
         tmo_cnt <= tmo_cnt + 16'd1;
   end
endmodule

// File: tb/tb_wb_rr_arbiter.sv
module tb_wb_rr_arbiter;
   localparam int TMO = 8;

   logic       clk;
   logic       rst;
   logic [1:0] gnt;

   wb_rr_arbiter_if #(.AW(32), .DW(128)) m0_bus ();
   wb_rr_arbiter_if #(.AW(32), .DW(128)) m1_bus ();
   wb_rr_arbiter_if #(.AW(32), .DW(128)) s_bus ();

   wb_rr_arbiter #(.TIMEOUT(TMO)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .m0    (m0_bus.slave),
      .m1    (m1_bus.slave),
      .s     (s_bus.master),
      .o_gnt (gnt)
   );

   logic [31:0]  adr_v  [2];
   logic [15:0]  sel_v  [2];
   logic         we_v   [2];
   logic [127:0] wdat_v [2];
   logic         cyc_v  [2];
   logic         stb_v  [2];
   logic [127:0] sdat;
   logic         sack;
   logic         serr;

   assign m0_bus.adr = adr_v[0];  assign m1_bus.adr = adr_v[1];
   assign m0_bus.sel = sel_v[0];  assign m1_bus.sel = sel_v[1];
   assign m0_bus.we = we_v[0];    assign m1_bus.we = we_v[1];
   assign m0_bus.dat_w = wdat_v[0]; assign m1_bus.dat_w = wdat_v[1];
   assign m0_bus.cyc = cyc_v[0];  assign m1_bus.cyc = cyc_v[1];
   assign m0_bus.stb = stb_v[0];  assign m1_bus.stb = stb_v[1];
   assign s_bus.dat_r = sdat;
   assign s_bus.ack = sack;
   assign s_bus.err = serr;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int checks = 0;
   int errors = 0;

   // Reference model: who owns the bus (-1 = nobody), who owned it last, and how many strobe
   // cycles the owner has already waited without a response.
   int owner;
   int last;
   int waited;
   bit exp_tmo;

   logic obs_ack0;
   logic obs_err0;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic compare_all();
      bit         g;
      int         o;
      logic [1:0] eg;
      logic       e_stb;
      g     = (owner >= 0);
      o     = g ? owner : 0;
      eg    = g ? 2'(1 << o) : 2'b00;
      e_stb = g & stb_v[o];
      exp_tmo = (TMO != 0) && e_stb && (waited == TMO) && !sack && !serr;
      chk("gnt",   gnt,           eg);
      chk("s_cyc", s_bus.cyc,     g ? cyc_v[o]  : 1'b0);
      chk("s_stb", s_bus.stb,     e_stb);
      chk("s_we",  s_bus.we,      g ? we_v[o]   : 1'b0);
      chk("s_adr", s_bus.adr,     g ? adr_v[o]  : 32'h0);
      chk("s_sel", s_bus.sel,     g ? sel_v[o]  : 16'h0);
      chk("s_dat", s_bus.dat_w,   g ? wdat_v[o] : 128'h0);
      for (int m = 0; m < 2; m++) begin
         bit mine;
         logic a, e;
         logic [127:0] d;
         mine = g && (o == m);
         a = (m == 0) ? m0_bus.ack : m1_bus.ack;
         e = (m == 0) ? m0_bus.err : m1_bus.err;
         d = (m == 0) ? m0_bus.dat_r : m1_bus.dat_r;
         chk($sformatf("m%0d_ack", m), a, mine & sack & stb_v[m]);
         chk($sformatf("m%0d_err", m), e, mine & stb_v[m] & (serr | exp_tmo));
         chk($sformatf("m%0d_dat", m), d, mine ? sdat : 128'h0);
      end
   endtask

   task automatic model_update();
      if (rst) begin
         owner = -1; last = 1; waited = 0;
      end else if (owner < 0) begin
         waited = 0;
         if (cyc_v[0] && cyc_v[1]) owner = (last == 1) ? 0 : 1;
         else if (cyc_v[0])        owner = 0;
         else if (cyc_v[1])        owner = 1;
      end else if (!cyc_v[owner]) begin
         last = owner; owner = -1; waited = 0;
      end else if (stb_v[owner] && !sack && !serr && !exp_tmo) begin
         waited = (waited < 65535) ? waited + 1 : 65535;
      end else begin
         waited = 0;
      end
   endtask

   // One clock: check outputs mid-cycle, then advance the model across the edge.
   task automatic step();
      #4;
      compare_all();
      obs_ack0 = m0_bus.ack;
      obs_err0 = m0_bus.err;
      @(posedge clk);
      model_update();
      #1;
   endtask

   initial begin
      int first_err, second_err, n_err;
      for (int m = 0; m < 2; m++) begin
         adr_v[m] = '0; sel_v[m] = '0; we_v[m] = 1'b0; wdat_v[m] = '0;
         cyc_v[m] = 1'b1; stb_v[m] = 1'b0;
      end
      sdat = 128'h0; sack = 1'b0; serr = 1'b0;
      exp_tmo = 1'b0;

      // Reset held three cycles with both masters requesting.
      rst = 1'b1;
      @(posedge clk);
      #1;
      owner = -1; last = 1; waited = 0;
      step(); step();
      chk("rst_gnt", gnt, 2'b00);
      chk("rst_s_cyc", s_bus.cyc, 1'b0);
      chk("rst_m0_ack", m0_bus.ack, 1'b0);

      // Single write by m0, slave acks after two wait cycles.
      rst = 1'b0;
      cyc_v[1] = 1'b0;
      cyc_v[0] = 1'b1; stb_v[0] = 1'b1; we_v[0] = 1'b1; adr_v[0] = 32'h100; sel_v[0] = 16'hFFFF;
      wdat_v[0] = 128'hF0081003_F0081003_F0081003_E3A01005;
      sdat = 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321;
      step();
      chk("single_gnt", gnt, 2'b01);
      chk("single_adr", s_bus.adr, 32'h100);
      step(); step();
      sack = 1'b1;
      step();
      chk("single_ack", obs_ack0, 1'b1);
      sack = 1'b0; cyc_v[0] = 1'b0; stb_v[0] = 1'b0; we_v[0] = 1'b0;
      step(); step();

      // Tie from reset: m0 first, idle bubble, then m1, then m0 again.
      rst = 1'b1; step(); rst = 1'b0;
      cyc_v[0] = 1'b1; cyc_v[1] = 1'b1;
      step();           chk("tie_first", gnt, 2'b01);
      cyc_v[0] = 1'b0;
      step();           chk("tie_bubble", gnt, 2'b00);
      step();           chk("tie_second", gnt, 2'b10);
      cyc_v[1] = 1'b0;
      step();           chk("tie_idle", gnt, 2'b00);
      cyc_v[0] = 1'b1; cyc_v[1] = 1'b1;
      step();           chk("tie_third", gnt, 2'b01);

      // m1 holds the bus while m0 keeps requesting; no preemption.
      cyc_v[0] = 1'b0;
      step(); step();   chk("hold_m1", gnt, 2'b10);
      cyc_v[0] = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step();
         chk("hold_no_preempt", gnt, 2'b10);
      end
      cyc_v[1] = 1'b0;
      step();           chk("hold_bubble", gnt, 2'b00);
      step();           chk("hold_m0", gnt, 2'b01);
      cyc_v[0] = 1'b0;
      step(); step();

      // Timeout: the slave never responds to m0.
      cyc_v[0] = 1'b1; stb_v[0] = 1'b1; we_v[0] = 1'b0; adr_v[0] = 32'h200;
      step();
      first_err = 0; second_err = 0; n_err = 0;
      for (int i = 1; i <= 20; i++) begin
         step();
         if (obs_err0) begin
            n_err++;
            if (n_err == 1) first_err = i;
            if (n_err == 2) second_err = i;
         end
      end
      chk("tmo_first", first_err, 9);
      chk("tmo_second", second_err, 18);
      chk("tmo_pulses", n_err, 2);

      // Race: slave ack lands exactly on the timeout cycle.
      stb_v[0] = 1'b0; step(); stb_v[0] = 1'b1;
      for (int i = 1; i <= 9; i++) begin
         sack = (i == 9);
         step();
      end
      chk("race_ack", obs_ack0, 1'b1);
      chk("race_err", obs_err0, 1'b0);
      sack = 1'b0;

      // Reset in the middle of a read with an ack pending.
      step();
      rst = 1'b1; sack = 1'b1;
      step();
      chk("midrst_s_cyc", s_bus.cyc, 1'b0);
      chk("midrst_m0_ack", m0_bus.ack, 1'b0);
      rst = 1'b0; sack = 1'b0;
      cyc_v[0] = 1'b0; stb_v[0] = 1'b0;
      step();

      // Randomized traffic against the model.
      for (int c = 0; c < 3000; c++) begin
         for (int m = 0; m < 2; m++) begin
            if (cyc_v[m]) begin
               if ($urandom_range(0, 9) == 0) cyc_v[m] = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
               cyc_v[m] = 1'b1;
            end
            stb_v[m]  = cyc_v[m] & ($urandom_range(0, 3) != 0);
            adr_v[m]  = $urandom;
            sel_v[m]  = 16'($urandom);
            we_v[m]   = 1'($urandom);
            wdat_v[m] = {$urandom, $urandom, $urandom, $urandom};
         end
         sdat = {$urandom, $urandom, $urandom, $urandom};
         sack = ($urandom_range(0, 3) == 0);
         serr = ($urandom_range(0, 15) == 0);
         rst  = ($urandom_range(0, 199) == 0);
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
